// File: rtl/base_emux_pkg.sv
// Shared sizing helpers for the pipelined emux/edemux trees, so gather and
// scatter trees built with the same select widths have identical latency.
package base_emux_pkg;

   function automatic int cdiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Select width rounded up to a whole number of per-level decode groups.
   function automatic int esel_w(input int sel_width, input int lsel_width);
      return cdiv(sel_width, lsel_width) * lsel_width;
   endfunction

   function automatic int levels(input int sel_width, input int lsel_width);
      return cdiv(sel_width, lsel_width);
   endfunction

endpackage

// File: rtl/base_edemux_mc_if.sv
// Word/select/sideband bundle for the pipelined demultiplexer.
interface base_edemux_mc_if #(
   parameter int width     = 1,
   parameter int ways      = 2,
   parameter int sel_width = $clog2(ways),
   parameter int aux_width = 1
);
   logic                     vin;
   logic [width-1:0]         din;
   logic [0:sel_width-1]     sel;
   logic [aux_width-1:0]     ain;
   logic [0:ways-1]          vout;
   logic [0:width*ways-1]    dout;
   logic [aux_width-1:0]     aout;
   logic                     oor;

   modport master (output vin, din, sel, ain, input vout, dout, aout, oor);
   modport slave  (input vin, din, sel, ain, output vout, dout, aout, oor);
endinterface

// File: rtl/base_edemux_lvl.sv
// One decode level: each parent branch fans out to 2**lsel_width children,
// registering child valid every cycle and child data only when selected.
module base_edemux_lvl
   import base_emux_pkg::*;
#(
   parameter int width      = 1,
   parameter int lsel_width = 3,
   parameter int nb         = 1,
   parameter int nd         = 8,
   parameter int aux_width  = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic [nb-1:0]                                        pv,
   input  logic [cdiv(nd, 2**lsel_width)-1:0][width-1:0]        pd,
   input  logic [lsel_width-1:0]                                slice,
   input  logic [aux_width-1:0]                                 ain,
   output logic [nb*2**lsel_width-1:0]                          cv,
   output logic [nd-1:0][width-1:0]                             cd,
   output logic [aux_width-1:0]                                 aout
);
   localparam int LWAYS = 2**lsel_width;

   logic [nb*LWAYS-1:0] hit;

   for (genvar n = 0; n < nb*LWAYS; n++) begin : g_br
      assign hit[n] = pv[n/LWAYS] && (slice == lsel_width'(n % LWAYS));
      base_vlat_en #(.w(1)) u_v (
         .clk, .rst_n, .en(1'b1), .d(hit[n]), .q(cv[n])
      );
      // Children that only lead to virtual lanes carry no data register.
      if (n < nd) begin : g_d
         base_vlat_en #(.w(width)) u_d (
            .clk, .rst_n, .en(hit[n]), .d(pd[n/LWAYS]), .q(cd[n])
         );
      end
   end

   base_vlat_en #(.w(aux_width)) u_aux (
      .clk, .rst_n, .en(1'b1), .d(ain), .q(aout)
   );
endmodule

// File: rtl/base_vlat_en.sv
// Enable-gated register with asynchronous active-low clear.
module base_vlat_en #(
   parameter int w = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [w-1:0] d,
   output logic [w-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/base_edemux_mc.sv
// Pipelined one-to-N demultiplexer: a chain of registered decode levels, each
// resolving lsel_width select bits, MSB group first.
module base_edemux_mc
   import base_emux_pkg::*;
#(
   parameter int width      = 1,
   parameter int ways       = 2,
   parameter int sel_width  = $clog2(ways),
   parameter int lsel_width = 3,
   parameter int aux_width  = 1
) (
   input  logic             clk,
   input  logic             reset,
   base_edemux_mc_if.slave  bus
);
   localparam int ESEL_W = esel_w(sel_width, lsel_width);
   localparam int L      = levels(sel_width, lsel_width);
   localparam int LWAYS  = 2**lsel_width;
   localparam int EWAYS  = 2**ESEL_W;

   logic [ESEL_W-1:0] esel;
   assign esel = ESEL_W'(bus.sel);

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int NB = LWAYS**k;
      localparam int ND = cdiv(ways, LWAYS**(L-1-k));
      localparam int NP = cdiv(ND, LWAYS);

      logic [NB-1:0]                pv;
      logic [NP-1:0][width-1:0]     pd;
      logic [aux_width-1:0]         pa;
      logic [NB*LWAYS-1:0]          cv;
      logic [ND-1:0][width-1:0]     cd;
      logic [aux_width-1:0]         ca;
      logic [k:0][lsel_width-1:0]   dl;

      // Group k is delayed k cycles so it meets its word at level k.
      assign dl[0] = esel[ESEL_W-1-k*lsel_width -: lsel_width];
      for (genvar s = 1; s <= k; s++) begin : g_dl
         base_vlat_en #(.w(lsel_width)) u_dl (
            .clk, .rst_n(reset), .en(1'b1), .d(dl[s-1]), .q(dl[s])
         );
      end

      if (k == 0) begin : g_head
         assign pv = bus.vin;
         assign pd = bus.din;
         assign pa = bus.ain;
      end else begin : g_link
         assign pv = g_lvl[k-1].cv;
         assign pd = g_lvl[k-1].cd;
         assign pa = g_lvl[k-1].ca;
      end

      base_edemux_lvl #(
         .width(width), .lsel_width(lsel_width), .nb(NB), .nd(ND), .aux_width(aux_width)
      ) u_lvl (
         .clk, .rst_n(reset), .pv, .pd, .slice(dl[k]), .ain(pa),
         .cv, .cd, .aout(ca)
      );
   end

   logic [EWAYS-1:0]            fv;
   logic [ways-1:0][width-1:0]  fd;
   logic [0:ways-1]             vo;
   logic [0:width*ways-1]       dd;

   assign fv = g_lvl[L-1].cv;
   assign fd = g_lvl[L-1].cd;

   for (genvar i = 0; i < ways; i++) begin : g_out
      assign vo[i]                = fv[i];
      assign dd[i*width +: width] = fd[i];
   end

   assign bus.vout = vo;
   assign bus.dout = dd;
   assign bus.aout = g_lvl[L-1].ca;

   // A word reaching a virtual lane is the out-of-range indication.
   if (EWAYS > ways) begin : g_oor
      assign bus.oor = |fv[EWAYS-1:ways];
   end else begin : g_no_oor
      assign bus.oor = 1'b0;
   end
endmodule
